// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between the command front-end and its neighbours: UART RX bytes in,
// ALU operands/enable out, ALU result in, UART TX bytes out, plus the error pulse.
interface alu_cmd_ctrl_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned FunWidth  = 4
);

  // UART RX side
  logic [DataWidth-1:0]   rx_p_data;
  logic                   rx_d_vld;

  // ALU side
  logic [2*DataWidth-1:0] alu_out;
  logic                   out_valid;
  logic [FunWidth-1:0]    alu_fun;
  logic [DataWidth-1:0]   a;
  logic [DataWidth-1:0]   b;
  logic                   alu_en;

  // UART TX side
  logic                   tx_rdy;
  logic [DataWidth-1:0]   tx_p_data;
  logic                   tx_d_vld;

  // Protocol / timeout error pulse
  logic                   cmd_err;

  // Environment view: drives RX bytes, the ALU result and TX readiness.
  modport master (
    output rx_p_data, rx_d_vld, alu_out, out_valid, tx_rdy,
    input  alu_fun, a, b, alu_en, tx_p_data, tx_d_vld, cmd_err
  );

  // Controller view.
  modport slave (
    input  rx_p_data, rx_d_vld, alu_out, out_valid, tx_rdy,
    output alu_fun, a, b, alu_en, tx_p_data, tx_d_vld, cmd_err
  );

endinterface

// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the ALU. Parses RX byte frames (CC,A,B,FUN or DD,FUN),
// runs one ALU operation per frame, captures the 16-bit result and streams it
// to TX low byte first. Protocol errors and ALU timeouts raise a one-cycle pulse.
module alu_cmd_ctrl #(
  parameter int unsigned    DataWidth   = 8,
  parameter int unsigned    FunWidth    = 4,
  parameter int unsigned    AluOutWidth = 2 * DataWidth,
  parameter int unsigned    Timeout     = 15,
  parameter logic [DataWidth-1:0] OpFull  = 8'hCC,
  parameter logic [DataWidth-1:0] OpNoper = 8'hDD
) (
  input logic          clk,
  input logic          rst,
  alu_cmd_ctrl_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(Timeout + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StGetFun,
    StAluRun,
    StSendLo,
    StSendHi
  } state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   a_q, a_d;
  logic [DataWidth-1:0]   b_q, b_d;
  logic [FunWidth-1:0]    fun_q, fun_d;
  logic                   alu_en_q, alu_en_d;
  logic [AluOutWidth-1:0] result_q, result_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   tx_vld_q, tx_vld_d;
  logic [DataWidth-1:0]   tx_data_q, tx_data_d;
  logic                   err_q, err_d;

  // Upper bits of the function byte must be clear for a legal function code.
  logic fun_byte_bad;
  assign fun_byte_bad = |bus.rx_p_data[DataWidth-1:FunWidth];

  // Next-state and next-output computation for the frame/run/send sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    alu_en_d  = alu_en_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    tx_vld_d  = tx_vld_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.rx_d_vld) begin
          if (bus.rx_p_data == OpFull) begin
            state_d = StGetA;
          end else if (bus.rx_p_data == OpNoper) begin
            state_d = StGetFun;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StGetA: begin
        if (bus.rx_d_vld) begin
          a_d     = bus.rx_p_data;
          state_d = StGetB;
        end
      end

      StGetB: begin
        if (bus.rx_d_vld) begin
          b_d     = bus.rx_p_data;
          state_d = StGetFun;
        end
      end

      StGetFun: begin
        if (bus.rx_d_vld) begin
          if (fun_byte_bad) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            fun_d    = bus.rx_p_data[FunWidth-1:0];
            cnt_d    = '0;
            alu_en_d = 1'b1;
            state_d  = StAluRun;
          end
        end
      end

      StAluRun: begin
        // Stray RX bytes are dropped; only the error pulse is visible.
        if (bus.rx_d_vld) begin
          err_d = 1'b1;
        end
        // Capture has priority over the timeout on the same cycle.
        if (bus.out_valid) begin
          result_d  = bus.alu_out;
          alu_en_d  = 1'b0;
          tx_vld_d  = 1'b1;
          tx_data_d = bus.alu_out[DataWidth-1:0];
          state_d   = StSendLo;
        end else if (cnt_q == CntWidth'(Timeout - 1)) begin
          err_d    = 1'b1;
          alu_en_d = 1'b0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSendLo: begin
        if (bus.rx_d_vld) begin
          err_d = 1'b1;
        end
        if (bus.tx_rdy) begin
          tx_data_d = result_q[AluOutWidth-1:DataWidth];
          state_d   = StSendHi;
        end
      end

      StSendHi: begin
        if (bus.rx_d_vld) begin
          err_d = 1'b1;
        end
        if (bus.tx_rdy) begin
          tx_vld_d = 1'b0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      fun_q     <= '0;
      alu_en_q  <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      fun_q     <= fun_d;
      alu_en_q  <= alu_en_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.alu_fun   = fun_q;
  assign bus.alu_en    = alu_en_q;
  assign bus.tx_d_vld  = tx_vld_q;
  assign bus.tx_p_data = tx_data_q;
  assign bus.cmd_err   = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed scenarios followed by random frames, checked
// against a byte-level protocol model and a transaction scoreboard.
module tb_alu_cmd_ctrl;

  localparam int unsigned TimeoutCycles = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_cmd_ctrl_if bus ();

  alu_cmd_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ALU behavioural model: result appears alu_lat cycles into the enable window.
  int            alu_lat   = 0;
  bit            alu_hang  = 1'b0;
  logic [15:0]   alu_value = 16'h0;
  int            en_cnt    = 0;

  always @(posedge clk) en_cnt <= bus.alu_en ? en_cnt + 1 : 0;
  assign bus.out_valid = bus.alu_en && !alu_hang && (en_cnt >= alu_lat);
  assign bus.alu_out   = alu_value;

  // TX readiness: either a fixed level or random back-pressure.
  bit rdy_rand  = 1'b0;
  bit rdy_fixed = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.tx_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  // Observation: error pulses, enable cycles, TX transfers and TX hold stability.
  int          err_seen = 0;
  int          en_seen  = 0;
  logic [7:0]  tx_seen[$];
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        prev_rst = 1'b1;
  logic [7:0]  prev_data = 8'h0;

  always @(negedge clk) begin
    if (bus.cmd_err) err_seen++;
    if (bus.alu_en) en_seen++;
    if (bus.tx_d_vld && bus.tx_rdy) tx_seen.push_back(bus.tx_p_data);
    if (prev_vld && !prev_rdy && !prev_rst) begin
      check_val("tx_hold_vld", {31'b0, bus.tx_d_vld}, 32'd1);
      check_val("tx_hold_data", {24'b0, bus.tx_p_data}, {24'b0, prev_data});
    end
    prev_vld  = bus.tx_d_vld;
    prev_rdy  = bus.tx_rdy;
    prev_rst  = rst;
    prev_data = bus.tx_p_data;
  end

  // Reference model: protocol interpreter at byte level plus expected totals.
  int          m_stage = 0;  // 0 opcode, 1 expect A, 2 expect B, 3 expect FUN
  logic [7:0]  m_a = 8'h0;
  logic [7:0]  m_b = 8'h0;
  logic [3:0]  m_fun = 4'h0;
  int          exp_err = 0;
  int          exp_en  = 0;
  logic [7:0]  exp_tx[$];

  task automatic model_reset();
    m_stage = 0;
    m_a     = 8'h0;
    m_b     = 8'h0;
    m_fun   = 4'h0;
  endtask

  task automatic model_byte(input logic [7:0] v);
    case (m_stage)
      0: begin
        if (v == 8'hCC) m_stage = 1;
        else if (v == 8'hDD) m_stage = 3;
        else exp_err++;
      end
      1: begin m_a = v; m_stage = 2; end
      2: begin m_b = v; m_stage = 3; end
      default: begin
        m_stage = 0;
        if (v[7:4] != 4'h0) begin
          exp_err++;
        end else begin
          m_fun = v[3:0];
          if (alu_hang) begin
            exp_err++;
            exp_en += TimeoutCycles;
          end else begin
            exp_en += alu_lat + 1;
            exp_tx.push_back(alu_value[7:0]);
            exp_tx.push_back(alu_value[15:8]);
          end
        end
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] v);
    @(posedge clk);
    #1;
    bus.rx_p_data = v;
    bus.rx_d_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic check_scoreboard(input string name);
    check_val({name, "_err_cnt"}, err_seen, exp_err);
    check_val({name, "_en_cycles"}, en_seen, exp_en);
    check_val({name, "_tx_cnt"}, tx_seen.size(), exp_tx.size());
    for (int i = 0; i < tx_seen.size() && i < exp_tx.size(); i++) begin
      check_val({name, "_tx_byte"}, {24'b0, tx_seen[i]}, {24'b0, exp_tx[i]});
    end
    check_val({name, "_a"}, {24'b0, bus.a}, {24'b0, m_a});
    check_val({name, "_b"}, {24'b0, bus.b}, {24'b0, m_b});
    check_val({name, "_fun"}, {28'b0, bus.alu_fun}, {28'b0, m_fun});
    check_val({name, "_tx_idle"}, {31'b0, bus.tx_d_vld}, 32'd0);
    check_val({name, "_en_idle"}, {31'b0, bus.alu_en}, 32'd0);
    err_seen = 0;
    en_seen  = 0;
    tx_seen.delete();
    exp_err  = 0;
    exp_en   = 0;
    exp_tx.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_a"}, {24'b0, bus.a}, 32'd0);
    check_val({name, "_b"}, {24'b0, bus.b}, 32'd0);
    check_val({name, "_fun"}, {28'b0, bus.alu_fun}, 32'd0);
    check_val({name, "_en"}, {31'b0, bus.alu_en}, 32'd0);
    check_val({name, "_tx_vld"}, {31'b0, bus.tx_d_vld}, 32'd0);
    check_val({name, "_tx_data"}, {24'b0, bus.tx_p_data}, 32'd0);
    check_val({name, "_err"}, {31'b0, bus.cmd_err}, 32'd0);
  endtask

  logic [7:0] frame_q[$];

  task automatic run_frame(input string name, input int lat, input bit hang,
                           input logic [15:0] val, input bit gaps);
    alu_lat   = lat;
    alu_hang  = hang;
    alu_value = val;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      model_byte(frame_q[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (60) @(posedge clk);
    #2;
    check_scoreboard(name);
  endtask

  initial begin
    bus.rx_p_data = 8'h0;
    bus.rx_d_vld  = 1'b0;
    bus.tx_rdy    = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    err_seen = 0;
    en_seen  = 0;
    tx_seen.delete();

    // Full frame, immediate result.
    frame_q = '{8'hCC, 8'h12, 8'h34, 8'h01};
    run_frame("full", 0, 1'b0, 16'hABCD, 1'b0);

    // Operand reuse.
    frame_q = '{8'hDD, 8'h03};
    run_frame("noper", 0, 1'b0, 16'h0046, 1'b0);

    // Bad opcode then bad function byte.
    frame_q = '{8'h55, 8'hCC, 8'h01, 8'h02, 8'hF0};
    run_frame("bad", 0, 1'b0, 16'h1111, 1'b0);

    // ALU never answers.
    frame_q = '{8'hDD, 8'h05};
    run_frame("timeout", 0, 1'b1, 16'h2222, 1'b0);

    // TX stall with a stray RX byte during SEND_LO.
    rdy_fixed = 1'b0;
    alu_lat   = 0;
    alu_hang  = 1'b0;
    alu_value = 16'h5A3C;
    frame_q = '{8'hCC, 8'h21, 8'h43, 8'h07};
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      model_byte(frame_q[i]);
    end
    send_byte(8'h77);
    exp_err++;
    repeat (4) @(posedge clk);
    rdy_fixed = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check_scoreboard("stall");

    // Reset while waiting for B.
    send_byte(8'hCC);
    model_byte(8'hCC);
    send_byte(8'h05);
    model_byte(8'h05);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_getb");
    model_reset();
    #2;
    check_scoreboard("rst_getb_sb");

    // Reset while the high byte is pending.
    rdy_fixed = 1'b0;
    alu_lat   = 0;
    alu_hang  = 1'b0;
    alu_value = 16'h9876;
    frame_q = '{8'hCC, 8'h0A, 8'h0B, 8'h02};
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      model_byte(frame_q[i]);
    end
    rdy_fixed = 1'b1;
    @(posedge clk);
    #2;
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_sendhi");
    model_reset();
    void'(exp_tx.pop_back());
    rdy_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_scoreboard("rst_sendhi_sb");

    frame_q = '{8'hCC, 8'h05, 8'h06, 8'h00};
    run_frame("after_rst", 2, 1'b0, 16'h0B0E, 1'b0);

    // Random frames with random latency, hangs and TX back-pressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [7:0] fb;
      kind = $urandom_range(0, 9);
      fb = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255))
                                       : 8'($urandom_range(0, 15));
      if (kind == 0) begin
        frame_q = '{8'($urandom_range(0, 255) & 8'h7F)};
      end else if (kind <= 5) begin
        frame_q = '{8'hCC, 8'($urandom), 8'($urandom), fb};
      end else begin
        frame_q = '{8'hDD, fb};
      end
      run_frame("rand", $urandom_range(0, 4), ($urandom_range(0, 5) == 0),
                16'($urandom), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
